// File: rtl/ysyx_23060208_axil_pkg.sv
// Shared definitions for the AXI4-Lite arbiter and the future crossbar:
// FSM state encodings, response codes and a width helper.
package ysyx_23060208_axil_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT_RD = 2'b01,
    ST_GRANT_WR = 2'b10
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Index width for n masters; a single master still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060208_rr_picker.sv
// Combinational round-robin select: the first requester at or after ptr,
// scanning upwards and wrapping modulo NM, wins.
module ysyx_23060208_rr_picker #(
  parameter int unsigned NM = 2,
  parameter int unsigned IW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  localparam logic [IW:0] NM_W = (IW+1)'(NM);

  logic [2*NM-1:0] req_dbl;
  logic [NM-1:0]   req_rot;
  logic [IW:0]     offset;
  logic [IW:0]     sum;

  // Doubling the vector turns the wrapping scan into a plain right shift.
  assign req_dbl = {req, req};
  assign req_rot = NM'(req_dbl >> ptr);

  // Lowest set bit of the rotated vector is the distance from ptr to the winner.
  always_comb begin
    grant_valid = 1'b0;
    offset      = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_valid = 1'b1;
        offset      = (IW+1)'(k);
      end
    end
  end

  // Map the distance back to an absolute master index.
  always_comb begin
    sum = {1'b0, ptr} + offset;
    if (sum >= NM_W) begin
      grant_idx = IW'(sum - NM_W);
    end else begin
      grant_idx = sum[IW-1:0];
    end
  end

endmodule

// File: rtl/ysyx_23060208_axil_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter with round-robin fairness and a
// single outstanding transaction. A grant is released only by the slave
// response handshake (R for reads, B for writes).
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   ST_IDLE     | no transaction; pick the next requester from rr_ptr
//   ST_GRANT_RD | AR/R routed between grant_id and the slave until R hs
//   ST_GRANT_WR | AW/W/B routed between grant_id and the slave until B hs
module ysyx_23060208_axil_rr_arbiter
  import ysyx_23060208_axil_pkg::*;
#(
  parameter int unsigned NM         = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned SW        = DATA_WIDTH / 8,
  localparam int unsigned IW        = idx_width(NM)
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [NM*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NM-1:0]            m_arvalid,
  output logic [NM-1:0]            m_arready,
  output logic [NM*DATA_WIDTH-1:0] m_rdata,
  output logic [NM*2-1:0]          m_rresp,
  output logic [NM-1:0]            m_rvalid,
  input  logic [NM-1:0]            m_rready,
  input  logic [NM*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NM-1:0]            m_awvalid,
  output logic [NM-1:0]            m_awready,
  input  logic [NM*DATA_WIDTH-1:0] m_wdata,
  input  logic [NM*SW-1:0]         m_wstrb,
  input  logic [NM-1:0]            m_wvalid,
  output logic [NM-1:0]            m_wready,
  output logic [NM*2-1:0]          m_bresp,
  output logic [NM-1:0]            m_bvalid,
  input  logic [NM-1:0]            m_bready,

  output logic [ADDR_WIDTH-1:0]    s_araddr,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [DATA_WIDTH-1:0]    s_rdata,
  input  logic [1:0]               s_rresp,
  input  logic                     s_rvalid,
  output logic                     s_rready,
  output logic [ADDR_WIDTH-1:0]    s_awaddr,
  output logic                     s_awvalid,
  input  logic                     s_awready,
  output logic [DATA_WIDTH-1:0]    s_wdata,
  output logic [SW-1:0]            s_wstrb,
  output logic                     s_wvalid,
  input  logic                     s_wready,
  input  logic [1:0]               s_bresp,
  input  logic                     s_bvalid,
  output logic                     s_bready,

  output logic [IW-1:0]            grant_id,
  output logic                     busy
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;

  logic [NM-1:0] req;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] next_ptr;

  assign req = m_arvalid | m_awvalid;

  ysyx_23060208_rr_picker #(
    .NM (NM),
    .IW (IW)
  ) u_picker (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // With a single master this folds to a constant zero.
  assign next_ptr = (grant_id_q == IW'(NM - 1)) ? '0 : grant_id_q + 1'b1;

  // State, pointer and grant registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Arbitrate in IDLE (read wins within a master); release on response handshake.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_idx;
          state_d    = m_arvalid[pick_idx] ? ST_GRANT_RD : ST_GRANT_WR;
        end
      end
      ST_GRANT_RD: begin
        if (s_rvalid && s_rready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      ST_GRANT_WR: begin
        if (s_bvalid && s_bready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Route the active channel group between the granted master and the slave;
  // everything else, data included, is held at zero.
  always_comb begin
    m_arready = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rvalid  = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bresp   = '0;
    m_bvalid  = '0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (IW'(i) == grant_id_q) begin
        if (state_q == ST_GRANT_RD) begin
          s_araddr                           = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s_arvalid                          = m_arvalid[i];
          s_rready                           = m_rready[i];
          m_arready[i]                       = s_arready;
          m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
          m_rresp[i*2 +: 2]                  = s_rresp;
          m_rvalid[i]                        = s_rvalid;
        end else if (state_q == ST_GRANT_WR) begin
          s_awaddr          = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          s_awvalid         = m_awvalid[i];
          s_wdata           = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          s_wstrb           = m_wstrb[i*SW +: SW];
          s_wvalid          = m_wvalid[i];
          s_bready          = m_bready[i];
          m_awready[i]      = s_awready;
          m_wready[i]       = s_wready;
          m_bresp[i*2 +: 2] = s_bresp;
          m_bvalid[i]       = s_bvalid;
        end
      end
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ysyx_23060208_axil_rr_arbiter.sv
// Directed bench for the round-robin AXI4-Lite arbiter (2 masters, 32/32).
module tb_ysyx_23060208_axil_rr_arbiter;
  import ysyx_23060208_axil_pkg::*;

  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM*AW-1:0] m_araddr;
  logic [NM-1:0]    m_arvalid, m_arready;
  logic [NM*DW-1:0] m_rdata;
  logic [NM*2-1:0]  m_rresp;
  logic [NM-1:0]    m_rvalid, m_rready;
  logic [NM*AW-1:0] m_awaddr;
  logic [NM-1:0]    m_awvalid, m_awready;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [NM-1:0]    m_wvalid, m_wready;
  logic [NM*2-1:0]  m_bresp;
  logic [NM-1:0]    m_bvalid, m_bready;
  logic [AW-1:0]    s_araddr, s_awaddr;
  logic             s_arvalid, s_arready;
  logic [DW-1:0]    s_rdata, s_wdata;
  logic [1:0]       s_rresp, s_bresp;
  logic             s_rvalid, s_rready;
  logic             s_awvalid, s_awready;
  logic [SW-1:0]    s_wstrb;
  logic             s_wvalid, s_wready;
  logic             s_bvalid, s_bready;
  logic [0:0]       grant_id;
  logic             busy;

  always #5 clk = ~clk;

  ysyx_23060208_axil_rr_arbiter #(
    .NM (NM), .DATA_WIDTH (DW), .ADDR_WIDTH (AW)
  ) dut (
    .clk (clk), .rst (rst),
    .m_araddr (m_araddr), .m_arvalid (m_arvalid), .m_arready (m_arready),
    .m_rdata (m_rdata), .m_rresp (m_rresp), .m_rvalid (m_rvalid), .m_rready (m_rready),
    .m_awaddr (m_awaddr), .m_awvalid (m_awvalid), .m_awready (m_awready),
    .m_wdata (m_wdata), .m_wstrb (m_wstrb), .m_wvalid (m_wvalid), .m_wready (m_wready),
    .m_bresp (m_bresp), .m_bvalid (m_bvalid), .m_bready (m_bready),
    .s_araddr (s_araddr), .s_arvalid (s_arvalid), .s_arready (s_arready),
    .s_rdata (s_rdata), .s_rresp (s_rresp), .s_rvalid (s_rvalid), .s_rready (s_rready),
    .s_awaddr (s_awaddr), .s_awvalid (s_awvalid), .s_awready (s_awready),
    .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_wvalid (s_wvalid), .s_wready (s_wready),
    .s_bresp (s_bresp), .s_bvalid (s_bvalid), .s_bready (s_bready),
    .grant_id (grant_id), .busy (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m_araddr  = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr  = '0; m_awvalid = '0; m_wdata  = '0;
    m_wstrb   = '0; m_wvalid  = '0; m_bready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // Serve one read as the slave; master exp_m must be the one routed through.
  task automatic rr_read(input int exp_m, input logic [31:0] data);
    int cyc;
    logic [31:0] got;
    cyc = 0;
    while (!s_arvalid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("rr_ar_seen", 64'(s_arvalid), 64'd1);
    chk("rr_grant", 64'(grant_id), 64'(exp_m));
    s_arready = 1'b1;
    settle();
    chk("rr_arready", 64'(m_arready), 64'(2'b01 << exp_m));
    step();
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = data;
    s_rresp   = RESP_OKAY;
    settle();
    got = m_rdata[exp_m*32 +: 32];
    chk("rr_rvalid", 64'(m_rvalid), 64'(2'b01 << exp_m));
    chk("rr_rdata", 64'(got), 64'(data));
    step();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    settle();
    chk("rr_idle_gap", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();
    settle();

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_s_ctrl", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 64'd0);
    chk("rst_m_ctrl", 64'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 64'd0);

    // Single master 0 read with 1-cycle arbitration latency
    m_araddr  = {32'h1111_1111, 32'h8000_0000};
    m_arvalid = 2'b01;
    m_rready  = 2'b01;
    settle();
    chk("t1_lat0_arvalid", 64'(s_arvalid), 64'd0);
    chk("t1_lat0_busy", 64'(busy), 64'd0);
    step();
    chk("t1_arvalid", 64'(s_arvalid), 64'd1);
    chk("t1_araddr", 64'(s_araddr), 64'h8000_0000);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant", 64'(grant_id), 64'd0);
    s_arready = 1'b1;
    settle();
    chk("t1_arready", 64'(m_arready), 64'b01);
    step();
    m_arvalid = '0;
    s_arready = 1'b0;
    settle();
    chk("t1_arvalid_drop", 64'(s_arvalid), 64'd0);
    step();
    step();
    s_rvalid = 1'b1;
    s_rdata  = 32'hDEAD_BEEF;
    settle();
    chk("t1_rdata", 64'(m_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("t1_rvalid", 64'(m_rvalid), 64'b01);
    chk("t1_rready", 64'(s_rready), 64'd1);
    step();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    settle();
    chk("t1_idle", 64'(busy), 64'd0);

    // Both masters reading continuously from reset: grants alternate 0,1,...
    do_reset();
    m_araddr  = {32'h8000_1000, 32'h8000_0000};
    m_arvalid = 2'b11;
    m_rready  = 2'b11;
    for (int t = 0; t < 8; t++) begin
      rr_read(t % 2, 32'hC0DE_0000 + 32'(t));
    end
    m_arvalid = '0;
    m_rready  = '0;

    // Master 1 write, W handshake before AW, B held until bready
    m_awaddr  = {32'hA000_03F8, 32'h5555_5555};
    m_wdata   = {32'h1234_5678, 32'h7777_7777};
    m_wstrb   = {4'b0011, 4'b1111};
    m_awvalid = 2'b10;
    m_wvalid  = 2'b10;
    step();
    chk("t3_grant", 64'(grant_id), 64'd1);
    chk("t3_awvalid", 64'(s_awvalid), 64'd1);
    chk("t3_awaddr", 64'(s_awaddr), 64'hA000_03F8);
    chk("t3_wvalid", 64'(s_wvalid), 64'd1);
    chk("t3_wdata", 64'(s_wdata), 64'h1234_5678);
    chk("t3_wstrb", 64'(s_wstrb), 64'h3);
    chk("t3_no_ar", 64'(s_arvalid), 64'd0);
    s_wready = 1'b1;
    settle();
    chk("t3_wready", 64'(m_wready), 64'b10);
    chk("t3_awready_early", 64'(m_awready), 64'b00);
    step();
    m_wvalid  = '0;
    s_wready  = 1'b0;
    s_awready = 1'b1;
    settle();
    chk("t3_awready", 64'(m_awready), 64'b10);
    chk("t3_wvalid_drop", 64'(s_wvalid), 64'd0);
    step();
    m_awvalid = '0;
    s_awready = 1'b0;
    s_bvalid  = 1'b1;
    s_bresp   = RESP_SLVERR;
    settle();
    chk("t3_bvalid", 64'(m_bvalid), 64'b10);
    chk("t3_bresp", 64'(m_bresp), 64'b1000);
    chk("t3_bready0", 64'(s_bready), 64'd0);
    step();
    chk("t3_held", 64'(busy), 64'd1);
    m_bready = 2'b10;
    settle();
    chk("t3_bready1", 64'(s_bready), 64'd1);
    step();
    s_bvalid = 1'b0;
    s_bresp  = RESP_OKAY;
    m_bready = '0;
    settle();
    chk("t3_idle", 64'(busy), 64'd0);

    // Master 0 read in flight blocks master 1 write until R handshake + 1 idle cycle
    m_araddr  = {32'h0, 32'h8000_0010};
    m_arvalid = 2'b01;
    step();
    chk("t4_grant_rd", 64'(grant_id), 64'd0);
    m_awaddr  = {32'hA000_0000, 32'h0};
    m_awvalid = 2'b10;
    s_arready = 1'b1;
    s_awready = 1'b1;
    settle();
    chk("t4_arready", 64'(m_arready), 64'b01);
    chk("t4_awready_blk", 64'(m_awready), 64'b00);
    chk("t4_awvalid_blk", 64'(s_awvalid), 64'd0);
    step();
    m_arvalid = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    s_rdata   = 32'h0BAD_F00D;
    settle();
    chk("t4_rready0", 64'(s_rready), 64'd0);
    chk("t4_awready_blk2", 64'(m_awready), 64'b00);
    step();
    chk("t4_held", 64'(busy), 64'd1);
    m_rready = 2'b01;
    settle();
    chk("t4_rready1", 64'(s_rready), 64'd1);
    step();
    s_rvalid = 1'b0;
    s_rdata  = '0;
    m_rready = '0;
    settle();
    chk("t4_gap_busy", 64'(busy), 64'd0);
    chk("t4_gap_awready", 64'(m_awready), 64'b00);
    step();
    chk("t4_grant_wr", 64'(grant_id), 64'd1);
    chk("t4_awvalid", 64'(s_awvalid), 64'd1);
    chk("t4_awready", 64'(m_awready), 64'b10);
    step();
    m_awvalid = '0;
    s_awready = 1'b0;
    s_bvalid  = 1'b1;
    m_bready  = 2'b10;
    settle();
    chk("t4_bvalid", 64'(m_bvalid), 64'b10);
    step();
    s_bvalid = 1'b0;
    m_bready = '0;
    settle();
    chk("t4_idle", 64'(busy), 64'd0);

    // Same master raises AR and AW together: read first, then write
    m_araddr  = {32'h0, 32'h8000_0020};
    m_awaddr  = {32'h0, 32'h9000_0000};
    m_arvalid = 2'b01;
    m_awvalid = 2'b01;
    m_rready  = 2'b01;
    step();
    chk("t5_arvalid", 64'(s_arvalid), 64'd1);
    chk("t5_no_aw", 64'(s_awvalid), 64'd0);
    s_arready = 1'b1;
    step();
    m_arvalid = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b1;
    settle();
    chk("t5_rvalid", 64'(m_rvalid), 64'b01);
    step();
    s_rvalid = 1'b0;
    m_rready = '0;
    settle();
    chk("t5_idle", 64'(busy), 64'd0);
    step();
    chk("t5_awvalid", 64'(s_awvalid), 64'd1);
    chk("t5_awaddr", 64'(s_awaddr), 64'h9000_0000);
    chk("t5_no_ar", 64'(s_arvalid), 64'd0);
    chk("t5_grant", 64'(grant_id), 64'd0);

    // Reset during GRANT_WR before bvalid
    s_awready = 1'b1;
    s_wready  = 1'b1;
    settle();
    chk("t6_pre_awready", 64'(m_awready), 64'b01);
    rst = 1'b1;
    step();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_grant", 64'(grant_id), 64'd0);
    chk("t6_s_ctrl", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 64'd0);
    chk("t6_m_ctrl", 64'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 64'd0);
    chk("t6_s_awaddr", 64'(s_awaddr), 64'd0);
    rst       = 1'b0;
    m_awvalid = '0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    m_araddr  = {32'h8000_2000, 32'h8000_3000};
    m_arvalid = 2'b11;
    m_rready  = 2'b11;
    step();
    chk("t6_ptr_reset", 64'(grant_id), 64'd0);
    rr_read(0, 32'hFACE_0001);
    m_arvalid = '0;
    m_rready  = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
